// File: rtl/cfu_channel_router.sv
// Steers core CFU requests to NUM_CHANNELS units and returns their responses strictly in issue order.
// Latency: request path is combinational; a response reaches resp_* one cycle after its channel handshake.
// Backpressure: a full ordering FIFO or a busy target stalls req; resp_ready low holds the output and all channels.
// Optional head-response timeout with discard of late responses: CFU_ROUTER_TIMEOUT_EN.
module cfu_channel_router #(
   parameter int NUM_CHANNELS   = 4,
   parameter int DEPTH          = 8,
   parameter int DATA_W         = 32,
   parameter int REQ_ID_W       = 3,
   parameter int CFU_ID_W       = 4,
   parameter int FUNC_W         = 10,
   parameter int STATUS_W       = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [CFU_ID_W-1:0]          req_cfu,
   input  logic [REQ_ID_W-1:0]          req_id,
   input  logic [FUNC_W-1:0]            req_func,
   input  logic [DATA_W-1:0]            req_data0,
   input  logic [DATA_W-1:0]            req_data1,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [REQ_ID_W-1:0]          resp_id,
   output logic [STATUS_W-1:0]          resp_status,
   output logic [DATA_W-1:0]            resp_data,
   output logic [NUM_CHANNELS-1:0]      ch_req_valid,
   input  logic [NUM_CHANNELS-1:0]      ch_req_ready,
   output logic [REQ_ID_W-1:0]          ch_req_id,
   output logic [FUNC_W-1:0]            ch_req_func,
   output logic [DATA_W-1:0]            ch_req_data0,
   output logic [DATA_W-1:0]            ch_req_data1,
   input  logic [NUM_CHANNELS-1:0]      ch_resp_valid,
   output logic [NUM_CHANNELS-1:0]      ch_resp_ready,
   input  logic [NUM_CHANNELS*STATUS_W-1:0] ch_resp_status,
   input  logic [NUM_CHANNELS*DATA_W-1:0]   ch_resp_data
);
   localparam int IDX_W = $clog2(NUM_CHANNELS + 1);
   localparam int AW    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] MARKER = IDX_W'(NUM_CHANNELS);

   logic [IDX_W-1:0]        fifo_idx [DEPTH];
   logic [REQ_ID_W-1:0]     fifo_id  [DEPTH];
   logic [AW:0]             wr_ptr, rd_ptr;
   logic                    fifo_full, fifo_empty, push, pop;
   logic [31:0]             cfu_ext;
   logic                    tgt_ok, tgt_rdy;
   logic [NUM_CHANNELS-1:0] blocked, dis_nz;
   logic [IDX_W-1:0]        head_idx;
   logic [REQ_ID_W-1:0]     head_id;
   logic                    head_real, head_mark, out_free, out_valid;
   logic                    hd_vld;
   logic [STATUS_W-1:0]     hd_status;
   logic [DATA_W-1:0]       hd_data;
   logic                    head_take, mark_take, tmo_fire;

   assign ch_req_id    = req_id;
   assign ch_req_func  = req_func;
   assign ch_req_data0 = req_data0;
   assign ch_req_data1 = req_data1;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   always_comb begin
      cfu_ext      = 32'(req_cfu);
      tgt_ok       = cfu_ext < 32'(NUM_CHANNELS);
      tgt_rdy      = 1'b0;
      ch_req_valid = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (tgt_ok && cfu_ext == 32'(i)) begin
            tgt_rdy         = ch_req_ready[i] & ~blocked[i];
            ch_req_valid[i] = req_valid & ~fifo_full & ~blocked[i];
         end
      end
      // Bad targets are accepted locally so the core always gets an answer.
      req_ready = tgt_ok ? (tgt_rdy & ~fifo_full) : ~fifo_full;
   end

   assign push      = req_valid & req_ready;
   assign head_idx  = fifo_idx[rd_ptr[AW-1:0]];
   assign head_id   = fifo_id[rd_ptr[AW-1:0]];
   assign head_mark = !fifo_empty && (head_idx == MARKER);
   assign head_real = !fifo_empty && (head_idx != MARKER);
   assign out_free  = !out_valid || resp_ready;

   always_comb begin
      hd_vld        = 1'b0;
      hd_status     = '0;
      hd_data       = '0;
      ch_resp_ready = dis_nz;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (head_real && head_idx == IDX_W'(i)) begin
            // A channel still owing discarded responses answers the stale request first.
            hd_vld    = ch_resp_valid[i] & ~dis_nz[i];
            hd_status = ch_resp_status[i*STATUS_W +: STATUS_W];
            hd_data   = ch_resp_data[i*DATA_W +: DATA_W];
            if (out_free) ch_resp_ready[i] = 1'b1;
         end
      end
   end

   assign head_take = hd_vld & out_free;
   assign mark_take = head_mark & out_free;
   assign pop       = head_take | mark_take | tmo_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_idx[wr_ptr[AW-1:0]] <= tgt_ok ? IDX_W'(cfu_ext) : MARKER;
         fifo_id[wr_ptr[AW-1:0]]  <= req_id;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         resp_id     <= '0;
         resp_status <= '0;
         resp_data   <= '0;
      end else if (out_free) begin
         out_valid <= pop;
         if (head_take) begin
            resp_id     <= head_id;
            resp_status <= hd_status;
            resp_data   <= hd_data;
         end else if (mark_take) begin
            resp_id     <= head_id;
            resp_status <= STATUS_W'(1);
            resp_data   <= '0;
         end else if (tmo_fire) begin
            resp_id     <= head_id;
            resp_status <= STATUS_W'(2);
            resp_data   <= '0;
         end
      end
   end

   assign resp_valid = out_valid;

`ifdef CFU_ROUTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]    tmo_cnt;
   logic [DEPTH-1:0] discard [NUM_CHANNELS];

   assign tmo_fire = head_real && !hd_vld && (tmo_cnt == TW'(TIMEOUT_CYCLES)) && out_free;

   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) dis_nz[i] = |discard[i];
   end
   assign blocked = dis_nz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) discard[i] <= '0;
      end else begin
         if (pop)
            tmo_cnt <= '0;
         else if (head_real && !hd_vld && tmo_cnt != TW'(TIMEOUT_CYCLES))
            tmo_cnt <= tmo_cnt + TW'(1);
         for (int i = 0; i < NUM_CHANNELS; i++)
            discard[i] <= discard[i] + DEPTH'(tmo_fire && head_idx == IDX_W'(i))
                                     - DEPTH'(dis_nz[i] && ch_resp_valid[i]);
      end
   end
`else
   assign tmo_fire = 1'b0;
   assign dis_nz   = '0;
   assign blocked  = '0;
`endif

endmodule
